concolic_trace_recorder: RTL and testbench

Response-side counterpart to the concolic stimulus driver. It samples the design-under-test outputs (two data words plus the obs bit) every enabled cycle during a run and tags each sample with a cycle stamp. Samples go into an on-chip trace buffer. After the run, the buffer drains over a valid/ready stream to the trace sink, which compares against the concolic engine's expected path.

---
 rtl/concolic_trace_pkg.sv | 39 +++
 rtl/concolic_trace_recorder_trace_ram.sv | 31 +++
 rtl/concolic_trace_recorder.sv | 128 ++++++++++++
 tb/tb_concolic_trace_recorder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/concolic_trace_pkg.sv
// Shared types and record layout for the concolic trace recorder.
// A trace record is {cycle, obs, out_a, out_b}, MSB first. The helpers below
// give field widths and bit offsets for any DW/CYCW. trace_rec_t is the record
// type at the default widths (DW=32, CYCW=16).
package concolic_trace_pkg;

  typedef enum logic [1:0] {IDLE, RECORD, DUMP} state_t;

  localparam int DEF_DW   = 32;
  localparam int DEF_CYCW = 16;

  function automatic int rec_w(input int dw, input int cycw);
    return cycw + 1 + 2 * dw;
  endfunction

  function automatic int off_b(input int dw);
    return 0 * dw;
  endfunction

  function automatic int off_a(input int dw);
    return dw;
  endfunction

  function automatic int off_obs(input int dw);
    return 2 * dw;
  endfunction

  function automatic int off_cyc(input int dw);
    return 2 * dw + 1;
  endfunction

  typedef struct packed {
    logic [DEF_CYCW-1:0] cycle;
    logic                obs;
    logic [DEF_DW-1:0]   out_a;
    logic [DEF_DW-1:0]   out_b;
  } trace_rec_t;

endpackage

// File: rtl/concolic_trace_recorder_trace_ram.sv
// trace_ram: simple dual-port trace buffer, one write port and one read port.
// The read is registered. rdata changes only on a read enable, so the
// presented record stays put while the sink stalls.
// Ports: clk, reset (clears the read register only), we/waddr/wdata,
// re/raddr, rdata.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 81
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/concolic_trace_recorder.sv
// concolic_trace_recorder: records DUT outputs {obs, out_a, out_b} with a cycle
// stamp during a run (start..stop). It then drains the records in write order
// over a valid/ready stream.
// Ports: clk, reset (sync, active high); start/stop run control;
// sample_en/out_a/out_b/obs sample inputs; rd_valid/rd_ready/rd_data/rd_last
// dump stream; busy, overflow, count, done status.
module concolic_trace_recorder
  import concolic_trace_pkg::*;
#(
  parameter int DW          = 32,
  parameter int CYCW        = 16,
  parameter int DEPTH       = 16,
  parameter int CHANGE_ONLY = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     sample_en,
  input  logic [DW-1:0]            out_a,
  input  logic [DW-1:0]            out_b,
  input  logic                     obs,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CYCW+2*DW:0]       rd_data,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = rec_w(DW, CYCW);

  state_t          state;
  logic [CYCW-1:0] cyc;
  logic [CW-1:0]   rd_ptr;
  logic [2*DW:0]   last_smp;
  logic [2*DW:0]   cur;
  logic            full, eligible, wr_en, re;

  assign cur  = {obs, out_a, out_b};
  assign busy = (state != IDLE);

  always_comb begin
    full     = (count == CW'(DEPTH));
    // count==0 marks the first sample of the run. Overflow cannot happen
    // before the first store, so this test is enough.
    eligible = (state == RECORD) && sample_en &&
               ((CHANGE_ONLY == 0) || (count == '0) || (cur != last_smp));
    wr_en    = eligible && !full;
    // Issue the first read on DUMP entry. After that, prefetch on each
    // non-final handshake to keep one record per cycle.
    re       = (state == DUMP) && (count != '0) &&
               (!rd_valid || (rd_ready && !rd_last));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cyc      <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      last_smp <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RECORD;
            cyc      <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            last_smp <= '0;
          end
        end
        RECORD: begin
          if (cyc != '1) cyc <= cyc + 1'b1;
          if (wr_en) begin
            count    <= count + 1'b1;
            last_smp <= cur;
          end
          if (eligible && full) overflow <= 1'b1;
          if (stop) begin
            state  <= DUMP;
            rd_ptr <= '0;
          end
        end
        DUMP: begin
          if (re) begin
            rd_ptr   <= rd_ptr + 1'b1;
            rd_valid <= 1'b1;
            rd_last  <= (rd_ptr == count - 1'b1);
          end else if (rd_valid && rd_ready) begin
            // The only handshake without a prefetch is the one on the final record.
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else if (!rd_valid && (count == '0)) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  trace_ram #(.DEPTH(DEPTH), .W(RW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (count[AW-1:0]),
    .wdata ({cyc, obs, out_a, out_b}),
    .re    (re),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_concolic_trace_recorder.sv
module tb_concolic_trace_recorder;
  import concolic_trace_pkg::*;

  localparam int DW    = 32;
  localparam int CYCW  = 16;
  localparam int RW    = rec_w(DW, CYCW);
  localparam int NC    = 3;
  localparam int BOUND = 200;

  // Three configs share stimulus: 0 = defaults, 1 = CHANGE_ONLY, 2 = DEPTH 4.
  function automatic int depth_of(input int c);
    return (c == 2) ? 4 : 16;
  endfunction
  function automatic int chg_of(input int c);
    return (c == 1) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic reset, start, stop, sample_en, obs, rd_ready;
  logic [DW-1:0] out_a, out_b;

  logic       rd_valid_o [NC];
  logic       rd_last_o  [NC];
  logic       busy_o     [NC];
  logic       ovf_o      [NC];
  logic       done_o     [NC];
  trace_rec_t rd_data_o  [NC];
  logic [4:0] count_o    [NC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int D = depth_of(g);
    logic [$clog2(D):0] cnt;
    logic [RW-1:0]      dat;
    concolic_trace_recorder #(.DW(DW), .CYCW(CYCW), .DEPTH(D), .CHANGE_ONLY(chg_of(g))) u_dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_en(sample_en),
      .out_a(out_a), .out_b(out_b), .obs(obs),
      .rd_valid(rd_valid_o[g]), .rd_ready(rd_ready), .rd_data(dat), .rd_last(rd_last_o[g]),
      .busy(busy_o[g]), .overflow(ovf_o[g]), .count(cnt), .done(done_o[g])
    );
    assign rd_data_o[g] = dat;
    assign count_o[g]   = 5'(cnt);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input int c, input logic act, input logic exp);
    chk($sformatf("%s[dut%0d]", nm, c), 128'(act), 128'(exp));
  endtask

  // ---------------- reference model (transaction level) ----------------
  trace_rec_t     mq      [NC][$];
  bit             m_ovf   [NC];
  logic [2*DW:0]  m_last  [NC];
  int             m_cyc;
  logic [CYCW-1:0] got_cyc [NC][$];
  bit             ready_pat[$];

  task automatic start_run(input bit with_stop);
    start = 1'b1; stop = with_stop; sample_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    for (int c = 0; c < NC; c++) begin
      mq[c].delete(); m_ovf[c] = 1'b0; m_last[c] = '0;
    end
    m_cyc = 0;
  endtask

  task automatic rec_cycle(input bit en, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input bit o, input bit stp, input bit junk_start);
    sample_en = en; out_a = a; out_b = b; obs = o; stop = stp; start = junk_start;
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      if (en) begin
        if (chg_of(c) == 0 || mq[c].size() == 0 || {o, a, b} != m_last[c]) begin
          if (mq[c].size() < depth_of(c)) begin
            mq[c].push_back('{cycle: m_cyc[CYCW-1:0], obs: o, out_a: a, out_b: b});
            m_last[c] = {o, a, b};
          end else m_ovf[c] = 1'b1;
        end
      end
    end
    if (m_cyc < (1 << CYCW) - 1) m_cyc++;
    #1;
    sample_en = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic check_after_record();
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("count_after_record[dut%0d]", c), 128'(count_o[c]), 128'(mq[c].size()));
      chkb("overflow_after_record", c, ovf_o[c], m_ovf[c]);
      chkb("busy_in_dump", c, busy_o[c], 1'b1);
    end
    @(posedge clk); #1;
  endtask

  // Expects the state to have entered DUMP one cycle ago (check_after_record
  // consumed the first DUMP cycle), so k counts from the second DUMP cycle.
  task automatic dump(input bit rand_rdy);
    int idx[NC]; bit seen[NC]; bit pv[NC]; bit pl[NC]; trace_rec_t pd[NC];
    bit pr; bit all; int n;
    for (int c = 0; c < NC; c++) begin
      idx[c] = 0; seen[c] = 0; pv[c] = 0; pl[c] = 0; pd[c] = '0; got_cyc[c].delete();
    end
    pr = 0; all = 0;
    for (int k = 0; k < BOUND && !all; k++) begin
      if (k < ready_pat.size()) rd_ready = ready_pat[k];
      else rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      stop = 1'($urandom_range(0, 1));
      @(negedge clk);
      all = 1;
      for (int c = 0; c < NC; c++) begin
        n = mq[c].size();
        if (seen[c]) begin
          chkb("done_single_pulse", c, done_o[c], 1'b0);
          chkb("valid_after_done", c, rd_valid_o[c], 1'b0);
        end else begin
          if (k == 0) begin
            chkb("valid_one_cycle_in", c, rd_valid_o[c], n > 0);
            chkb("empty_done", c, done_o[c], n == 0);
          end
          if (pv[c] && !pr) begin
            chkb("stall_valid", c, rd_valid_o[c], 1'b1);
            chk($sformatf("stall_data[dut%0d]", c), 128'(rd_data_o[c]), 128'(pd[c]));
            chkb("stall_last", c, rd_last_o[c], pl[c]);
          end
          if (rd_valid_o[c]) begin
            chkb("rd_last", c, rd_last_o[c], idx[c] == n - 1);
            if (rd_ready) begin
              if (idx[c] < n)
                chk($sformatf("rd_data[dut%0d]", c), 128'(rd_data_o[c]), 128'(mq[c][idx[c]]));
              else
                chk($sformatf("record_in_range[dut%0d]", c), 128'(idx[c]), 128'(n - 1));
              got_cyc[c].push_back(rd_data_o[c].cycle);
              idx[c]++;
            end
          end
          if (done_o[c]) begin
            seen[c] = 1;
            chk($sformatf("xfers_at_done[dut%0d]", c), 128'(idx[c]), 128'(n));
            chkb("valid_at_done", c, rd_valid_o[c], 1'b0);
            chkb("busy_at_done", c, busy_o[c], 1'b0);
            chk($sformatf("count_kept[dut%0d]", c), 128'(count_o[c]), 128'(n));
            chkb("overflow_kept", c, ovf_o[c], m_ovf[c]);
          end
        end
        pv[c] = rd_valid_o[c]; pl[c] = rd_last_o[c]; pd[c] = rd_data_o[c];
        if (!seen[c]) all = 0;
      end
      pr = rd_ready;
      @(posedge clk); #1;
    end
    for (int c = 0; c < NC; c++) chkb("done_seen", c, seen[c], 1'b1);
    rd_ready = 1'b0; stop = 1'b0;
  endtask

  // ---------------- directed table: basic run ----------------
  typedef struct {
    bit st, sp, en; logic [DW-1:0] a, b; bit o, rdy;
    bit e_valid, e_last, e_busy, e_done; int e_cnt; bit chk_data; trace_rec_t e_data;
  } vec_t;

  function automatic vec_t mk(input bit st, sp, en, input int a, b, input bit o, rdy,
                              input bit ev, el, eb, ed, input int ec, input bit cd,
                              input int cy, input bit dobs, input int da, db);
    vec_t v;
    v.st = st; v.sp = sp; v.en = en; v.a = DW'(a); v.b = DW'(b); v.o = o; v.rdy = rdy;
    v.e_valid = ev; v.e_last = el; v.e_busy = eb; v.e_done = ed; v.e_cnt = ec; v.chk_data = cd;
    v.e_data = '{cycle: CYCW'(cy), obs: dobs, out_a: DW'(da), out_b: DW'(db)};
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 0; stop = 0; sample_en = 0; obs = 0; rd_ready = 0;
    out_a = '0; out_b = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      chkb("reset_valid", c, rd_valid_o[c], 1'b0);
      chkb("reset_busy", c, busy_o[c], 1'b0);
      chkb("reset_done", c, done_o[c], 1'b0);
      chkb("reset_ovf", c, ovf_o[c], 1'b0);
      chk($sformatf("reset_count[dut%0d]", c), 128'(count_o[c]), 128'(0));
    end
    @(posedge clk); #1;
    reset = 1'b0;

    //          st sp en  a  b  o rdy | v  l  b  d cnt cd  cyc obs a  b
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 2, 0, 0,   0, 0, 1, 0, 0,  0,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 3, 4, 1, 0,   0, 0, 1, 0, 1,  0,  0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 5, 6, 0, 0,   0, 0, 1, 0, 2,  0,  0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 3,  0,  0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 3,  0,  0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 3,  1,  0, 0, 1, 2);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 3,  1,  1, 1, 3, 4);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0, 3,  1,  2, 0, 5, 6);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 3,  0,  0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3,  0,  0, 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; sample_en = tbl[i].en;
      out_a = tbl[i].a; out_b = tbl[i].b; obs = tbl[i].o; rd_ready = tbl[i].rdy;
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        chkb($sformatf("tbl%0d_valid", i), c, rd_valid_o[c], tbl[i].e_valid);
        chkb($sformatf("tbl%0d_last", i), c, rd_last_o[c], tbl[i].e_last);
        chkb($sformatf("tbl%0d_busy", i), c, busy_o[c], tbl[i].e_busy);
        chkb($sformatf("tbl%0d_done", i), c, done_o[c], tbl[i].e_done);
        chkb($sformatf("tbl%0d_ovf", i), c, ovf_o[c], 1'b0);
        chk($sformatf("tbl%0d_count[dut%0d]", i, c), 128'(count_o[c]), 128'(tbl[i].e_cnt));
        if (tbl[i].chk_data)
          chk($sformatf("tbl%0d_data[dut%0d]", i, c), 128'(rd_data_o[c]), 128'(tbl[i].e_data));
      end
      @(posedge clk); #1;
    end
    start = 0; stop = 0; sample_en = 0; rd_ready = 0;

    // CHANGE_ONLY: duplicates collapse on dut1 only.
    start_run(0);
    rec_cycle(1, 7, 7, 0, 0, 0);
    rec_cycle(1, 7, 7, 0, 0, 0);
    rec_cycle(1, 8, 7, 0, 0, 0);
    rec_cycle(1, 8, 7, 0, 0, 0);
    rec_cycle(1, 8, 7, 1, 0, 0);
    rec_cycle(0, 0, 0, 0, 1, 0);
    check_after_record();
    dump(0);
    chk("chg_stamp_count", 128'(got_cyc[1].size()), 128'(3));
    for (int i = 0; i < 3; i++)
      if (i < got_cyc[1].size()) chk($sformatf("chg_stamp%0d", i), 128'(got_cyc[1][i]), 128'(2 * i));
    chk("nochg_stamp_count", 128'(got_cyc[0].size()), 128'(5));

    // Overflow on the DEPTH=4 instance; stop arrives with the last sample.
    start_run(0);
    for (int i = 0; i < 6; i++) rec_cycle(1, i + 10, i, 1'(i), i == 5, 0);
    check_after_record();
    dump(0);
    chk("ovf_stamp_count", 128'(got_cyc[2].size()), 128'(4));
    for (int i = 0; i < 4; i++)
      if (i < got_cyc[2].size()) chk($sformatf("ovf_stamp%0d", i), 128'(got_cyc[2][i]), 128'(i));

    // Backpressure on a 3-record dump.
    start_run(0);
    for (int i = 0; i < 3; i++) rec_cycle(1, 40 + i, 50 + i, 1'(i), 0, 0);
    rec_cycle(0, 0, 0, 0, 1, 0);
    check_after_record();
    ready_pat = '{1, 0, 0, 1, 0, 1};
    dump(0);
    ready_pat.delete();

    // Empty run; start and stop together in IDLE (start wins).
    start_run(1);
    rec_cycle(0, 0, 0, 0, 1, 0);
    check_after_record();
    dump(0);

    // Reset mid-dump, after the first transfer.
    start_run(0);
    for (int i = 0; i < 3; i++) rec_cycle(1, 90 + i, i, 0, i == 2, 0);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chkb("rst_dump_first_valid", 0, rd_valid_o[0], 1'b1);
    chk("rst_dump_first_stamp", 128'(rd_data_o[0].cycle), 128'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rd_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        chkb("rst_mid_valid", c, rd_valid_o[c], 1'b0);
        chkb("rst_mid_busy", c, busy_o[c], 1'b0);
        chkb("rst_mid_done", c, done_o[c], 1'b0);
        chk($sformatf("rst_mid_count[dut%0d]", c), 128'(count_o[c]), 128'(0));
      end
      @(posedge clk); #1;
    end

    // Randomized runs against the model.
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(0, 20);
      start_run(0);
      if (n == 0) rec_cycle(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < n; i++)
        rec_cycle(($urandom_range(0, 2) != 0), $urandom_range(0, 2), $urandom_range(0, 1),
                  1'($urandom_range(0, 1)), i == n - 1, 1'($urandom_range(0, 1)));
      check_after_record();
      dump(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
